rf_access_seq: RTL and testbench
================================

# rf_access_seq

Port sequencer that is the initiator side of the single-port register file interface (shared 5-bit address, OE, Wr, 32-bit write and read data). It accepts one instruction-level register request (two source reads, optional destination write) over a valid/ready handshake. It serialises the request into individual port cycles and returns both operands over a valid/ready response channel. It sits between the decode/execute control and the register file instance at the CPU top level.

## Interface
Parameters:
- RF_ADDR_W, 5, register address width
- RF_DATA_W, 32, register data width

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_rs  in  RF_ADDR_W  first source register
- req_rt  in  RF_ADDR_W  second source register
- req_rd  in  RF_ADDR_W  destination register
- req_we  in  1  destination write requested
- req_wdata  in  RF_DATA_W  destination write data
- rsp_valid  out  1  operands available
- rsp_ready  in  1  consumer takes operands
- rsp_a  out  RF_DATA_W  value of rs
- rsp_b  out  RF_DATA_W  value of rt
- rf_reg  out  RF_ADDR_W  register file address
- rf_oe  out  1  register file output enable
- rf_wr  out  1  register file write enable
- rf_wdata  out  RF_DATA_W  register file write data
- rf_rdata  in  RF_DATA_W  register file read data; high-Z when rf_oe=0

## Operation
- Request fields latch on the handshake (req_valid & req_ready). req_ready=1 only in IDLE.
- FSM states are IDLE, RD_A, RD_B, WR, RESP.
  - IDLE: on handshake go to RD_A.
  - RD_A: rf_reg=rs, rf_oe=1. Capture rf_rdata into a_q at end of cycle. Go to RD_B.
  - RD_B: rf_reg=rt, rf_oe=1. Capture into b_q. Go to WR if we=1 and rd!=0, else RESP.
  - WR: rf_reg=rd, rf_wdata=wdata, rf_wr=1, rf_oe=0 for exactly one cycle. Go to RESP.
  - RESP: rsp_valid=1, rsp_a=a_q, rsp_b=b_q. Go to IDLE on rsp_ready.
- Reads always precede the write, so operands return pre-write values even when rd equals rs or rt.
- rf_oe and rf_wr are never both 1. rf_rdata is sampled only in cycles with rf_oe=1.
- Writes to register 0 are suppressed (no WR cycle).
- Outside RD_x/WR: rf_oe=0, rf_wr=0, rf_reg=0, rf_wdata=0.

## Timing
- Reset values: req_ready=0 while rst=1, then 1 in IDLE. rsp_valid=0, rsp_a=rsp_b=0, rf_reg=0, rf_oe=0, rf_wr=0, rf_wdata=0.
- Latency from handshake cycle to first rsp_valid cycle:
  - 3 cycles when no write.
  - 4 cycles when a write is performed.
- RF samples the write on the negedge within the WR cycle. The write is complete before the next posedge.
- rsp backpressure: rsp_valid, rsp_a and rsp_b hold stable until rsp_ready. req_ready stays 0 throughout.
- After the rsp handshake, the FSM returns to IDLE. The next request is acceptable one cycle later; there is no same-cycle turnaround.
- rst mid-operation: takes effect at the next posedge. FSM goes to IDLE, the latched request is discarded, and rsp_valid drops. A WR cycle already in progress in the cycle rst rises still completes its write; no later write occurs.

## Configuration
- RF_SEQ_ZERO_SKIP_EN defined:
  - RD_A is skipped (a_q=0) when rs=0, and RD_B is skipped (b_q=0) when rt=0.
  - rf_oe is never asserted for register 0.
  - Latency shrinks by one cycle per skipped read; minimum is 1 cycle (rs=rt=0, no write).
- Undefined: both read cycles always execute. Register 0 returns 0 via the register file.

## Structure
- Shared package rf_pkg holds:
  - RF_ADDR_W and RF_DATA_W constants
  - the FSM state enum typedef
  - the request struct (rs, rt, rd, we, wdata)
- No sub-module is natural: a single FSM module. The register file is instanced beside it at CPU top level.

## Test plan
- Reset: hold rst 2 cycles, release. Expect req_ready=1, rsp_valid=0, rf_oe=0, rf_wr=0, rf_reg=0.
- Read pair: preload r1=0x11111111, r2=0x22222222. Request rs=1, rt=2, we=0. Expect rsp_valid 3 cycles after handshake with rsp_a=0x11111111, rsp_b=0x22222222, and no rf_wr pulse.
- Read-before-write: r3=0x00000005. Request rs=3, rt=3, rd=3, we=1, wdata=0xDEADBEEF.
  - Expect rsp_a=rsp_b=0x00000005 after 4 cycles.
  - Expect a single-cycle rf_wr with rf_reg=3.
  - A follow-up read of r3 returns 0xDEADBEEF.
- Register zero: request rs=0, rt=0, rd=0, we=1. Expect rsp_a=rsp_b=0 and no rf_wr.
  - With RF_SEQ_ZERO_SKIP_EN: rsp_valid 1 cycle after handshake and rf_oe never high.
  - Without it: 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles. Expect rsp_valid and data stable and req_ready=0. A new request is accepted 1 cycle after the rsp handshake.
- Reset mid-op: assert rst during RD_B with a we=1 request pending. Expect IDLE next cycle, rsp_valid=0, and no rf_wr ever.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file types: address/data widths, sequencer states, request and port-cycle structs.
package rf_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_B,
    ST_WR,
    ST_RESP
  } rf_state_e;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] rs;
    logic [RF_ADDR_W-1:0] rt;
    logic [RF_ADDR_W-1:0] rd;
    logic                 we;
    logic [RF_DATA_W-1:0] wdata;
  } rf_req_t;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic                 oe;
    logic                 wr;
    logic [RF_DATA_W-1:0] wdata;
  } rf_port_t;

  // Register 0 is hardwired, so a write there is dropped entirely.
  function automatic logic req_writes(rf_req_t r);
    return r.we && (r.rd != '0);
  endfunction

endpackage

// File: rtl/rf_access_seq.sv
// Serialises one rs/rt read + optional rd write onto the single-port RF; 3 cycles to rsp (4 with write).
// Holds rsp until rsp_ready, req_ready only in IDLE. RF_SEQ_ZERO_SKIP_EN skips reads of register 0.
module rf_access_seq #(
  parameter int RF_ADDR_W = 5,
  parameter int RF_DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [RF_ADDR_W-1:0] req_rs,
  input  logic [RF_ADDR_W-1:0] req_rt,
  input  logic [RF_ADDR_W-1:0] req_rd,
  input  logic                 req_we,
  input  logic [RF_DATA_W-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [RF_DATA_W-1:0] rsp_a,
  output logic [RF_DATA_W-1:0] rsp_b,
  output logic [RF_ADDR_W-1:0] rf_reg,
  output logic                 rf_oe,
  output logic                 rf_wr,
  output logic [RF_DATA_W-1:0] rf_wdata,
  input  logic [RF_DATA_W-1:0] rf_rdata
);
  import rf_pkg::*;

`ifdef RF_SEQ_ZERO_SKIP_EN
  localparam bit ZERO_SKIP = 1'b1;
`else
  localparam bit ZERO_SKIP = 1'b0;
`endif

  rf_state_e state;
  rf_req_t   req_q;
  rf_req_t   req_in;
  rf_port_t  port_q;
  logic [RF_DATA_W-1:0] a_q;
  logic [RF_DATA_W-1:0] b_q;

  assign req_in = '{rs: req_rs, rt: req_rt, rd: req_rd, we: req_we, wdata: req_wdata};

  function automatic rf_state_e after_rd_b(rf_req_t r);
    return req_writes(r) ? ST_WR : ST_RESP;
  endfunction

  function automatic rf_state_e after_rd_a(rf_req_t r);
    return (ZERO_SKIP && r.rt == '0) ? after_rd_b(r) : ST_RD_B;
  endfunction

  function automatic rf_state_e after_idle(rf_req_t r);
    return (ZERO_SKIP && r.rs == '0) ? after_rd_a(r) : ST_RD_A;
  endfunction

  // Port pins are registered, so they are computed for the state being entered.
  function automatic rf_port_t port_for(rf_state_e s, rf_req_t r);
    rf_port_t p;
    p = '0;
    case (s)
      ST_RD_A: begin p.addr = r.rs; p.oe = 1'b1; end
      ST_RD_B: begin p.addr = r.rt; p.oe = 1'b1; end
      ST_WR:   begin p.addr = r.rd; p.wr = 1'b1; p.wdata = r.wdata; end
      default: ;
    endcase
    return p;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      req_q     <= '0;
      port_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_q     <= req_in;
            a_q       <= '0;
            b_q       <= '0;
            state     <= after_idle(req_in);
            port_q    <= port_for(after_idle(req_in), req_in);
            rsp_valid <= (after_idle(req_in) == ST_RESP);
          end
        end
        ST_RD_A: begin
          a_q       <= rf_rdata;
          state     <= after_rd_a(req_q);
          port_q    <= port_for(after_rd_a(req_q), req_q);
          rsp_valid <= (after_rd_a(req_q) == ST_RESP);
        end
        ST_RD_B: begin
          b_q       <= rf_rdata;
          state     <= after_rd_b(req_q);
          port_q    <= port_for(after_rd_b(req_q), req_q);
          rsp_valid <= (after_rd_b(req_q) == ST_RESP);
        end
        ST_WR: begin
          state     <= ST_RESP;
          port_q    <= '0;
          rsp_valid <= 1'b1;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          port_q    <= '0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = (state == ST_IDLE) && !rst;
  assign rsp_a     = a_q;
  assign rsp_b     = b_q;
  assign rf_reg    = port_q.addr;
  assign rf_oe     = port_q.oe;
  assign rf_wr     = port_q.wr;
  assign rf_wdata  = port_q.wdata;

endmodule

// File: tb/tb_rf_access_seq.sv
// Bench for rf_access_seq: RF model on the port, directed cases plus random requests vs. a register-array reference.
module tb_rf_access_seq;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_rs;
  logic [4:0]  req_rt;
  logic [4:0]  req_rd;
  logic        req_we;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_a;
  logic [31:0] rsp_b;
  logic [4:0]  rf_reg;
  logic        rf_oe;
  logic        rf_wr;
  logic [31:0] rf_wdata;
  wire  [31:0] rf_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  // Register file attached to the DUT port; writes land on the negedge of the WR cycle.
  logic [31:0] rf_mem [32] = '{default: 32'h0};
  int          wr_count    = 0;
  int          clash_count = 0;
  int          oe0_count   = 0;
  logic [4:0]  last_wr_reg = '0;
  logic [31:0] last_wr_dat = '0;

  // Expected architectural register contents.
  logic [31:0] ref_rf [32] = '{default: 32'h0};

  assign rf_rdata = rf_oe ? ((rf_reg == 5'd0) ? 32'h0 : rf_mem[rf_reg]) : 32'hzzzz_zzzz;

  always @(negedge clk) begin
    if (rf_wr === 1'b1) begin
      rf_mem[rf_reg] <= rf_wdata;
      wr_count       <= wr_count + 1;
      last_wr_reg    <= rf_reg;
      last_wr_dat    <= rf_wdata;
    end
    if (rf_wr === 1'b1 && rf_oe === 1'b1) clash_count <= clash_count + 1;
    if (rf_oe === 1'b1 && rf_reg == 5'd0) oe0_count <= oe0_count + 1;
  end

  rf_access_seq #(.RF_ADDR_W(5), .RF_DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rs    (req_rs),
    .req_rt    (req_rt),
    .req_rd    (req_rd),
    .req_we    (req_we),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_a     (rsp_a),
    .rsp_b     (rsp_b),
    .rf_reg    (rf_reg),
    .rf_oe     (rf_oe),
    .rf_wr     (rf_wr),
    .rf_wdata  (rf_wdata),
    .rf_rdata  (rf_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("req_ready_wait", {31'b0, req_ready}, 32'd1);
  endtask

  // One full transaction with bp cycles of response backpressure.
  task automatic do_req(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic we, input logic [31:0] wd, input int bp);
    int          n;
    int          wr0;
    int          exp_lat;
    bit          does_wr;
    logic [31:0] ea;
    logic [31:0] eb;
    ea      = ref_rf[rs];
    eb      = ref_rf[rt];
    does_wr = we && (rd != 5'd0);
`ifdef RF_SEQ_ZERO_SKIP_EN
    exp_lat = 1 + int'(rs != 5'd0) + int'(rt != 5'd0) + int'(does_wr);
`else
    exp_lat = 3 + int'(does_wr);
`endif
    wait_ready();
    wr0       = wr_count;
    req_valid = 1'b1;
    req_rs    = rs;
    req_rt    = rt;
    req_rd    = rd;
    req_we    = we;
    req_wdata = wd;
    step();
    // Scramble the bus so a sequencer that fails to latch is exposed.
    req_valid = 1'b0;
    req_rs    = 5'($urandom);
    req_rt    = 5'($urandom);
    req_rd    = 5'($urandom);
    req_we    = 1'($urandom);
    req_wdata = $urandom;
    check("req_ready_busy", {31'b0, req_ready}, 32'd0);
    n = 1;
    while (rsp_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("latency", n, exp_lat);
    for (int i = 0; i < bp; i++) begin
      step();
      check("bp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_rsp_a", rsp_a, ea);
      check("bp_ready", {31'b0, req_ready}, 32'd0);
    end
    check("rsp_a", rsp_a, ea);
    check("rsp_b", rsp_b, eb);
    check("resp_req_ready", {31'b0, req_ready}, 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("rsp_drop", {31'b0, rsp_valid}, 32'd0);
    check("ready_after_rsp", {31'b0, req_ready}, 32'd1);
    check("wr_pulses", wr_count - wr0, int'(does_wr));
    if (does_wr) begin
      check("wr_reg", {27'b0, last_wr_reg}, {27'b0, rd});
      check("wr_data", last_wr_dat, wd);
      ref_rf[rd] = wd;
    end
  endtask

  initial begin
    int wr_before;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_rs    = '0;
    req_rt    = '0;
    req_rd    = '0;
    req_we    = 1'b0;
    req_wdata = '0;
    rsp_ready = 1'b0;

    step();
    step();
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_a", rsp_a, 32'd0);
    check("rst_rsp_b", rsp_b, 32'd0);
    rst = 1'b0;
    #1;
    check("idle_req_ready", {31'b0, req_ready}, 32'd1);
    check("idle_rf_oe", {31'b0, rf_oe}, 32'd0);
    check("idle_rf_wr", {31'b0, rf_wr}, 32'd0);
    check("idle_rf_reg", {27'b0, rf_reg}, 32'd0);
    check("idle_rf_wdata", rf_wdata, 32'd0);

    // Preload through the sequencer itself.
    do_req(5'd0, 5'd0, 5'd1, 1'b1, 32'h1111_1111, 0);
    do_req(5'd0, 5'd0, 5'd2, 1'b1, 32'h2222_2222, 0);
    do_req(5'd0, 5'd0, 5'd3, 1'b1, 32'h0000_0005, 0);

    do_req(5'd1, 5'd2, 5'd7, 1'b0, 32'hAAAA_AAAA, 0);
    do_req(5'd3, 5'd3, 5'd3, 1'b1, 32'hDEAD_BEEF, 0);
    do_req(5'd3, 5'd1, 5'd0, 1'b0, 32'h0, 0);
    do_req(5'd0, 5'd0, 5'd0, 1'b1, 32'hCAFE_F00D, 0);
    do_req(5'd2, 5'd1, 5'd4, 1'b1, 32'h4444_4444, 5);

    // Reset while in RD_B with a write pending: the write must never happen.
    wait_ready();
    wr_before = wr_count;
    req_valid = 1'b1;
    req_rs    = 5'd1;
    req_rt    = 5'd2;
    req_rd    = 5'd5;
    req_we    = 1'b1;
    req_wdata = 32'h5555_5555;
    step();
    req_valid = 1'b0;
    check("midrst_rd_a_reg", {27'b0, rf_reg}, 32'd1);
    step();
    check("midrst_rd_b_oe", {31'b0, rf_oe}, 32'd1);
    check("midrst_rd_b_reg", {27'b0, rf_reg}, 32'd2);
    rst = 1'b1;
    step();
    check("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("midrst_rf_oe", {31'b0, rf_oe}, 32'd0);
    check("midrst_rf_wr", {31'b0, rf_wr}, 32'd0);
    check("midrst_req_ready", {31'b0, req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("midrst_idle", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) step();
    check("midrst_no_wr", wr_count - wr_before, 32'd0);
    check("midrst_rsp_quiet", {31'b0, rsp_valid}, 32'd0);

    for (int t = 0; t < 40; t++) begin
      do_req(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             1'($urandom), $urandom, $urandom_range(0, 3));
    end

    check("oe_wr_clash", clash_count, 32'd0);
`ifdef RF_SEQ_ZERO_SKIP_EN
    check("oe_reg0", oe0_count, 32'd0);
`endif
    for (int r = 0; r < 8; r++) begin
      check("rf_final", rf_mem[r], ref_rf[r]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
